// File: rtl/riscv_mem_pkg.sv
// Shared load/store and result-select encodings for the memory stage.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC  = 2'b10;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
  } m_reg_t;

  // Only halfword and word codes carry an alignment constraint.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic w_bad;
    w_bad = 1'b0;
    if ((funct3 == F3_H) || (funct3 == F3_HU)) w_bad = addr_lo[0];
    else if (funct3 == F3_W)                   w_bad = |addr_lo;
    return w_bad;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised RAM: byte-enable synchronous write, combinational read. Contents are not reset.
module data_memory #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_phase.sv
// Pipeline M stage: E->M register with stall/flush, data-memory access and load extension.
module memory_phase
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallM,
  input  logic        FlushM,
  input  logic [31:0] ALUResult_E,
  input  logic [31:0] WriteData_E,
  input  logic [4:0]  Rd_E,
  input  logic [31:0] PC_Plus4_E,
  input  logic        RegWrite_E,
  input  logic        MemWrite_E,
  input  logic [1:0]  ResultSrc_E,
  input  logic [2:0]  Funct3_E,
  output logic [31:0] ALUResult_M,
  output logic [4:0]  RdM,
  output logic [31:0] PC_Plus4M,
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM
);

  localparam int unsigned AW = $clog2(DEPTH);

  m_reg_t          r_m;
  m_reg_t          w_e;
  logic [AW-1:0]   w_addr;
  logic [1:0]      w_lo;
  logic            w_we;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rword;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_e = '{alu_result: ALUResult_E, write_data: WriteData_E, rd: Rd_E,
                 pc_plus4: PC_Plus4_E, reg_write: RegWrite_E, mem_write: MemWrite_E,
                 result_src: ResultSrc_E, funct3: Funct3_E};

  // Flush outranks stall; a flushed slot is an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_m <= '0;
    else if (FlushM)  r_m <= '0;
    else if (!StallM) r_m <= w_e;
  end

  assign ALUResult_M = r_m.alu_result;
  assign RdM         = r_m.rd;
  assign PC_Plus4M   = r_m.pc_plus4;
  assign RegWriteM   = r_m.reg_write;
  assign ResultSrcM  = r_m.result_src;

  assign w_addr    = r_m.alu_result[AW+1:2];
  assign w_lo      = r_m.alu_result[1:0];
  assign MisalignM = (r_m.mem_write || (r_m.result_src == RES_MEM)) &&
                     is_misaligned(r_m.funct3, w_lo);

  // A stalled store retries on the release edge, so it commits exactly once.
  assign w_we = r_m.mem_write && !MisalignM && !StallM && rst_n;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = r_m.write_data;
    case (r_m.funct3)
      F3_B: begin
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{r_m.write_data[7:0]}};
      end
      F3_H: begin
        w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_m.write_data[15:0]}};
      end
      F3_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  data_memory #(
    .DEPTH(DEPTH)
  ) u_data_memory (
    .clk    (clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_addr (w_addr),
    .i_wdata(w_wdata),
    .o_rdata(w_rword)
  );

  assign w_byte = w_rword[{w_lo, 3'b000} +: 8];
  assign w_half = w_lo[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    ReadDataM = w_rword;
    if (MisalignM) begin
      ReadDataM = '0;
    end else begin
      case (r_m.funct3)
        F3_B:    ReadDataM = {{24{w_byte[7]}}, w_byte};
        F3_H:    ReadDataM = {{16{w_half[15]}}, w_half};
        F3_W:    ReadDataM = w_rword;
        F3_BU:   ReadDataM = {24'h0, w_byte};
        F3_HU:   ReadDataM = {16'h0, w_half};
        default: ReadDataM = w_rword;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_phase.sv
// Randomised and directed bench for memory_phase against a byte-array reference model.
module tb_memory_phase;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NB    = DEPTH * 4;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
  } ins_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  ins_t        e;
  ins_t        m;
  logic [7:0]  mem_q [NB];
  logic        rd_known;
  int          n_vec;
  int          n_err;
  logic [31:0] old_word;

  logic [31:0] alu_m, pc_m, rdata_m;
  logic [4:0]  rd_m;
  logic        rw_m, mis_m;
  logic [1:0]  rs_m;

  memory_phase #(
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallM     (stall),
    .FlushM     (flush),
    .ALUResult_E(e.alu),
    .WriteData_E(e.wd),
    .Rd_E       (e.rd),
    .PC_Plus4_E (e.pc),
    .RegWrite_E (e.rw),
    .MemWrite_E (e.mw),
    .ResultSrc_E(e.rs),
    .Funct3_E   (e.f3),
    .ALUResult_M(alu_m),
    .RdM        (rd_m),
    .PC_Plus4M  (pc_m),
    .RegWriteM  (rw_m),
    .ResultSrcM (rs_m),
    .ReadDataM  (rdata_m),
    .MisalignM  (mis_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic mdl_mis(input ins_t i);
    logic acc, bad;
    acc = i.mw || (i.rs == 2'b01);
    bad = ((i.f3 == 3'd1 || i.f3 == 3'd5) && i.alu[0]) || (i.f3 == 3'd2 && i.alu[1:0] != 2'b00);
    return acc && bad;
  endfunction

  function automatic int byte_idx(input logic [31:0] addr);
    return int'(addr % NB);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    int a;
    a = byte_idx(addr) & ~3;
    return {mem_q[a+3], mem_q[a+2], mem_q[a+1], mem_q[a]};
  endfunction

  function automatic logic [31:0] mdl_load(input ins_t i);
    int a, ah;
    logic [7:0]  b;
    logic [15:0] h;
    a  = byte_idx(i.alu);
    ah = a & ~1;
    b  = mem_q[a];
    h  = {mem_q[ah+1], mem_q[ah]};
    if (mdl_mis(i)) return 32'h0;
    case (i.f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return word_at(i.alu);
    endcase
  endfunction

  task automatic mdl_store(input ins_t i);
    int a;
    a = byte_idx(i.alu);
    case (i.f3)
      3'd0: mem_q[a] = i.wd[7:0];
      3'd1: begin
        mem_q[a & ~1]       = i.wd[7:0];
        mem_q[(a & ~1) + 1] = i.wd[15:8];
      end
      3'd2: for (int k = 0; k < 4; k++) mem_q[(a & ~3) + k] = i.wd[8*k +: 8];
      default: ;
    endcase
  endtask

  task automatic check_all();
    check_eq("alu_m", alu_m, m.alu);
    check_eq("rd_m", 32'(rd_m), 32'(m.rd));
    check_eq("pc_m", pc_m, m.pc);
    check_eq("rw_m", 32'(rw_m), 32'(m.rw));
    check_eq("rs_m", 32'(rs_m), 32'(m.rs));
    check_eq("misalign", 32'(mis_m), 32'(mdl_mis(m)));
    if (rd_known) check_eq("rdata", rdata_m, mdl_load(m));
  endtask

  // Advance one clock: update the model for the edge, then compare after it.
  task automatic step();
    if (rst_n) begin
      if (m.mw && !mdl_mis(m) && !stall) mdl_store(m);
      if (flush)       m = '0;
      else if (!stall) m = e;
    end else begin
      m = '0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    e = '{alu: addr, wd: data, rd: 5'd0, pc: $urandom, rw: 1'b0, mw: 1'b1, rs: 2'b00, f3: f3};
  endtask

  task automatic set_ld(input logic [2:0] f3, input logic [31:0] addr);
    e = '{alu: addr, wd: $urandom, rd: 5'($urandom_range(1, 31)), pc: $urandom, rw: 1'b1,
          mw: 1'b0, rs: 2'b01, f3: f3};
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rd_known = 1'b0;
    rst_n    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    e        = '0;
    m        = '0;
    for (int k = 0; k < NB; k++) mem_q[k] = 8'h00;

    step();
    check_eq("reset_alu", alu_m, 32'h0);
    check_eq("reset_rw", 32'(rw_m), 32'h0);
    #3 rst_n = 1'b1;

    // Fill memory so every later load has a known reference value.
    for (int w = 0; w < DEPTH; w++) begin
      set_st(3'd2, 32'(w * 4), $urandom);
      step();
    end
    set_ld(3'd2, 32'h0);
    rd_known = 1'b1;
    step();

    set_st(3'd2, 32'h10, 32'h8000_00F1); step();
    set_ld(3'd0, 32'h10); step();
    check_eq("lb_0x10", rdata_m, 32'hFFFF_FFF1);
    set_ld(3'd4, 32'h13); step();
    check_eq("lbu_0x13", rdata_m, 32'h0000_0080);

    set_st(3'd2, 32'h20, 32'h1234_5678); step();
    set_st(3'd1, 32'h22, 32'h0000_BEEF); step();
    set_ld(3'd2, 32'h20); step();
    check_eq("sh_lw_0x20", rdata_m, 32'hBEEF_5678);

    set_st(3'd2, 32'h21, 32'hFFFF_FFFF); step();
    check_eq("sw_mis", 32'(mis_m), 32'h1);
    set_ld(3'd2, 32'h20); step();
    check_eq("mis_no_write", rdata_m, 32'hBEEF_5678);
    set_ld(3'd2, 32'h22); step();
    check_eq("lw_mis_flag", 32'(mis_m), 32'h1);
    check_eq("lw_mis_data", rdata_m, 32'h0);

    // Stalled store: memory must not change until the release edge.
    old_word = word_at(32'h30);
    set_st(3'd2, 32'h30, 32'hCAFE_F00D); step();
    stall = 1'b1;
    set_ld(3'd2, 32'h30);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall_hold", rdata_m, old_word);
    end
    stall = 1'b0; step();
    check_eq("stall_commit", rdata_m, 32'hCAFE_F00D);

    old_word = word_at(32'h40);
    set_st(3'd2, 32'h40, 32'hDEAD_BEEF);
    e.rw = 1'b1;
    e.rd = 5'd7;
    flush = 1'b1; stall = 1'b1; step();
    check_eq("flush_rw", 32'(rw_m), 32'h0);
    check_eq("flush_rd", 32'(rd_m), 32'h0);
    flush = 1'b0; stall = 1'b0;
    set_ld(3'd2, 32'h40); step();
    check_eq("flush_nostore", rdata_m, old_word);

    // Reset asserted mid-stall with a store waiting in M.
    old_word = word_at(32'h50);
    set_st(3'd2, 32'h50, 32'h5A5A_5A5A); step();
    stall = 1'b1;
    set_ld(3'd2, 32'h50); step();
    #2 rst_n = 1'b0;
    m = '0;
    #1;
    check_eq("arst_alu", alu_m, 32'h0);
    check_eq("arst_pc", pc_m, 32'h0);
    check_eq("arst_rd", 32'(rd_m), 32'h0);
    check_eq("arst_rw", 32'(rw_m), 32'h0);
    check_eq("arst_rs", 32'(rs_m), 32'h0);
    step(); step();
    #2 rst_n = 1'b1;
    stall = 1'b0;
    set_ld(3'd2, 32'h50); step();
    check_eq("arst_nostore", rdata_m, old_word);

    for (int n = 0; n < 600; n++) begin
      e.alu = $urandom;
      if ($urandom_range(0, 1) == 0) e.alu[1:0] = 2'b00;
      e.wd  = $urandom;
      e.rd  = 5'($urandom_range(0, 31));
      e.pc  = $urandom;
      e.rw  = 1'($urandom_range(0, 1));
      e.mw  = ($urandom_range(0, 2) == 0);
      e.rs  = 2'($urandom_range(0, 3));
      e.f3  = 3'($urandom_range(0, 7));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
